// File: rtl/cluster_to_vpf.sv
// Rebuilds a per-frame valid-pattern-flag map from a stream of cluster start addresses.
// The last completed frame is published with its distinct cluster count and an overflow flag.
module cluster_to_vpf #(
    parameter int MXCLUSTERS = 8
) (
    input  logic           clock4x,
    input  logic           reset,
    input  logic           clst_valid,
    input  logic           clst_sof,
    input  logic           clst_eof,
    input  logic [10:0]    clst_adr,
    output logic [1535:0]  vpfs,
    output logic [7:0]     cnt,
    output logic           overflow,
    output logic           frame_valid,
    output logic           err
);

    localparam int NPADS = 1536;

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t           state;
    state_t           state_next;
    logic [NPADS-1:0] acc;
    logic [NPADS-1:0] acc_next;
    logic [7:0]       count;
    logic [7:0]       count_next;
    logic             accept;
    logic             addr_ok;
    logic             dup;
    logic             err_next;
    logic             publish;

    // A word is applied when it opens a frame or arrives while one is open.
    assign accept  = clst_valid && (clst_sof || state == COLLECT);
    assign addr_ok = clst_adr < 11'd1536;

    always_ff @(posedge clock4x) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (accept) state_next = clst_eof ? IDLE : COLLECT;
    end

    always_comb begin
        acc_next   = clst_sof ? '0 : acc;
        count_next = clst_sof ? 8'd0 : count;
        dup        = addr_ok && !clst_sof && acc[clst_adr];
        if (accept && addr_ok && !dup) begin
            acc_next[clst_adr] = 1'b1;
            count_next = (count_next == 8'hFF) ? 8'hFF : count_next + 8'd1;
        end
        // An sof that abandons an open frame counts as an error even though the word is applied.
        err_next = clst_valid && ((clst_sof && state == COLLECT) ||
                                  (!clst_sof && state == IDLE) ||
                                  (accept && (!addr_ok || dup)));
        publish  = accept && clst_eof;
    end

    always_ff @(posedge clock4x) begin
        if (reset) begin
            acc         <= '0;
            count       <= 8'd0;
            vpfs        <= '0;
            cnt         <= 8'd0;
            overflow    <= 1'b0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (accept) begin
                acc   <= acc_next;
                count <= count_next;
            end
            frame_valid <= publish;
            err         <= err_next;
            if (publish) begin
                vpfs     <= acc_next;
                cnt      <= count_next;
                overflow <= 32'(count_next) > MXCLUSTERS;
            end
        end
    end

endmodule

// File: tb/tb_cluster_to_vpf.sv
// Directed self-checking bench for cluster_to_vpf; each word is checked one cycle after it is applied.
module tb_cluster_to_vpf;

    logic          clock4x = 1'b0;
    logic          reset;
    logic          clst_valid;
    logic          clst_sof;
    logic          clst_eof;
    logic [10:0]   clst_adr;
    logic [1535:0] vpfs;
    logic [7:0]    cnt;
    logic          overflow;
    logic          frame_valid;
    logic          err;

    int            vectorCount = 0;
    int            miscompareCount = 0;
    logic [1535:0] expMap;

    cluster_to_vpf #(.MXCLUSTERS(8)) dut (
        .clock4x     (clock4x),
        .reset       (reset),
        .clst_valid  (clst_valid),
        .clst_sof    (clst_sof),
        .clst_eof    (clst_eof),
        .clst_adr    (clst_adr),
        .vpfs        (vpfs),
        .cnt         (cnt),
        .overflow    (overflow),
        .frame_valid (frame_valid),
        .err         (err)
    );

    always #5 clock4x = ~clock4x;

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkMap(input string tag, input logic [1535:0] observed, input logic [1535:0] expected);
        for (int s = 0; s < 6; s++)
            checkOutput($sformatf("%s[%0d]", tag, s), observed[s*256 +: 256], expected[s*256 +: 256]);
    endtask

    // Drives one word, lets the DUT clock it, and returns just after the edge so registered results are visible.
    task automatic applyStimulus(input logic v, input logic s, input logic e, input logic [10:0] a);
        clst_valid = v;
        clst_sof   = s;
        clst_eof   = e;
        clst_adr   = a;
        @(posedge clock4x);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clst_valid = 1'b0; clst_sof = 1'b0; clst_eof = 1'b0; clst_adr = 11'd0;
        repeat (3) @(posedge clock4x);
        #1;
        checkOutput("rst_fv",  256'(frame_valid), 256'(0));
        checkOutput("rst_err", 256'(err),         256'(0));
        checkOutput("rst_cnt", 256'(cnt),         256'(0));
        checkOutput("rst_ovf", 256'(overflow),    256'(0));
        checkMap("rst_vpfs", vpfs, '0);
        reset = 1'b0;

        // Three-cluster frame ending on the top pad
        applyStimulus(1, 1, 0, 11'd5);
        checkOutput("f1_fv0", 256'(frame_valid), 256'(0));
        applyStimulus(1, 0, 0, 11'd100);
        applyStimulus(1, 0, 1, 11'd1535);
        checkOutput("f1_fv",  256'(frame_valid), 256'(1));
        checkOutput("f1_cnt", 256'(cnt),         256'(3));
        checkOutput("f1_ovf", 256'(overflow),    256'(0));
        checkOutput("f1_err", 256'(err),         256'(0));
        expMap = '0; expMap[5] = 1'b1; expMap[100] = 1'b1; expMap[1535] = 1'b1;
        checkMap("f1_vpfs", vpfs, expMap);
        applyStimulus(0, 0, 0, 11'd0);
        checkOutput("hold_fv",  256'(frame_valid), 256'(0));
        checkOutput("hold_cnt", 256'(cnt),         256'(3));

        // Nine clusters overflow, eight do not
        for (int i = 0; i < 9; i++) applyStimulus(1, i == 0, i == 8, 11'(i));
        checkOutput("f9_fv",  256'(frame_valid), 256'(1));
        checkOutput("f9_cnt", 256'(cnt),         256'(9));
        checkOutput("f9_ovf", 256'(overflow),    256'(1));
        expMap = '0; expMap[8:0] = 9'h1FF;
        checkMap("f9_vpfs", vpfs, expMap);
        for (int i = 0; i < 8; i++) applyStimulus(1, i == 0, i == 7, 11'(i + 20));
        checkOutput("f8_cnt", 256'(cnt),      256'(8));
        checkOutput("f8_ovf", 256'(overflow), 256'(0));

        // Duplicate and out-of-range addresses
        applyStimulus(1, 1, 0, 11'd10);
        checkOutput("dup_err0", 256'(err), 256'(0));
        applyStimulus(1, 0, 0, 11'd10);
        checkOutput("dup_err1", 256'(err), 256'(1));
        applyStimulus(1, 0, 1, 11'd2000);
        checkOutput("dup_err2", 256'(err),         256'(1));
        checkOutput("dup_fv",   256'(frame_valid), 256'(1));
        checkOutput("dup_cnt",  256'(cnt),         256'(1));
        expMap = '0; expMap[10] = 1'b1;
        checkMap("dup_vpfs", vpfs, expMap);

        // Single-word frame followed by a back-to-back frame
        applyStimulus(1, 1, 1, 11'd7);
        checkOutput("b2b_fv1",  256'(frame_valid), 256'(1));
        checkOutput("b2b_cnt1", 256'(cnt),         256'(1));
        applyStimulus(1, 1, 0, 11'd3);
        checkOutput("b2b_fv0",  256'(frame_valid), 256'(0));
        checkOutput("b2b_err0", 256'(err),         256'(0));
        applyStimulus(1, 0, 0, 11'd20);
        applyStimulus(1, 0, 1, 11'd30);
        checkOutput("b2b_fv2",  256'(frame_valid), 256'(1));
        checkOutput("b2b_cnt2", 256'(cnt),         256'(3));

        // Second sof abandons the open frame
        applyStimulus(1, 1, 0, 11'd1);
        applyStimulus(1, 1, 0, 11'd2);
        checkOutput("resof_err", 256'(err), 256'(1));
        applyStimulus(1, 0, 1, 11'd4);
        checkOutput("resof_fv",  256'(frame_valid), 256'(1));
        checkOutput("resof_cnt", 256'(cnt),         256'(2));
        expMap = '0; expMap[2] = 1'b1; expMap[4] = 1'b1;
        checkMap("resof_vpfs", vpfs, expMap);

        // Control bits are ignored while valid is low
        applyStimulus(1, 1, 0, 11'd50);
        applyStimulus(0, 1, 1, 11'd60);
        checkOutput("nv_fv",  256'(frame_valid), 256'(0));
        checkOutput("nv_err", 256'(err),         256'(0));
        applyStimulus(1, 0, 1, 11'd70);
        checkOutput("nv_cnt", 256'(cnt), 256'(2));
        expMap = '0; expMap[50] = 1'b1; expMap[70] = 1'b1;
        checkMap("nv_vpfs", vpfs, expMap);

        // Zero-cluster frame from an invalid single word
        applyStimulus(1, 1, 1, 11'd1600);
        checkOutput("zero_fv",  256'(frame_valid), 256'(1));
        checkOutput("zero_err", 256'(err),         256'(1));
        checkOutput("zero_cnt", 256'(cnt),         256'(0));
        checkMap("zero_vpfs", vpfs, '0);

        // Counter saturates at 255
        for (int i = 0; i < 300; i++) applyStimulus(1, i == 0, i == 299, 11'(i));
        checkOutput("sat_cnt", 256'(cnt),      256'(255));
        checkOutput("sat_ovf", 256'(overflow), 256'(1));
        expMap = '0;
        for (int i = 0; i < 300; i++) expMap[i] = 1'b1;
        checkMap("sat_vpfs", vpfs, expMap);

        // Reset mid-frame discards it; a following eof-only word is an error
        applyStimulus(1, 1, 0, 11'd1);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 11'd0);
        checkOutput("mid_rst_fv",  256'(frame_valid), 256'(0));
        checkOutput("mid_rst_err", 256'(err),         256'(0));
        checkOutput("mid_rst_cnt", 256'(cnt),         256'(0));
        reset = 1'b0;
        applyStimulus(1, 0, 1, 11'd9);
        checkOutput("post_rst_err", 256'(err),         256'(1));
        checkOutput("post_rst_fv",  256'(frame_valid), 256'(0));
        checkOutput("post_rst_cnt", 256'(cnt),         256'(0));
        checkMap("post_rst_vpfs", vpfs, '0);
        applyStimulus(0, 0, 0, 11'd0);
        checkOutput("err_width", 256'(err), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
